// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the five-stage RISC-V pipeline:
//   XLEN / ILEN     - datapath and instruction widths
//   NOP_INSTR       - canonical bubble (addi x0,x0,0)
//   RS1/RS2/RD_LSB  - register-specifier field positions in a 32-bit instruction
//   PC_INC          - sequential fetch increment
// Helper functions pull the rs1/rs2 fields out of an instruction word.
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned ILEN    = 32;
    localparam int unsigned REG_W   = 5;

    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC    = 64'd4;

    function automatic logic [REG_W-1:0] get_rs1(input logic [ILEN-1:0] instr);
        return instr[RS1_LSB +: REG_W];
    endfunction

    function automatic logic [REG_W-1:0] get_rs2(input logic [ILEN-1:0] instr);
        return instr[RS2_LSB +: REG_W];
    endfunction

endpackage : pipe_pkg

// File: rtl/if_id_stage_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard detector.
// Ports:
//   if_id_instr_i    - instruction currently in IF/ID
//   if_id_valid_i    - IF/ID holds a real instruction
//   id_ex_mem_read_i - the instruction in ID/EX is a load
//   id_ex_rd_i       - destination register of the instruction in ID/EX
//   branch_taken_i   - taken branch resolved downstream (suppresses the stall)
//   stall_o          - hold PC and IF/ID for one edge, bubble ID/EX
// Both rs1 and rs2 fields are compared for every format; a spurious stall on
// formats without rs2 costs one cycle and is harmless.
// ----------------------------------------------------------------------------
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [ILEN-1:0]  if_id_instr_i,
    input  logic             if_id_valid_i,
    input  logic             id_ex_mem_read_i,
    input  logic [REG_W-1:0] id_ex_rd_i,
    input  logic             branch_taken_i,
    output logic             stall_o
);

    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rd_nonzero;
    logic             rd_match;

    assign rs1        = get_rs1(if_id_instr_i);
    assign rs2        = get_rs2(if_id_instr_i);
    assign rd_nonzero = (id_ex_rd_i != '0);
    assign rd_match   = (id_ex_rd_i == rs1) || (id_ex_rd_i == rs2);

    // A taken branch discards the would-be stalled instruction, so it wins.
    assign stall_o = if_id_valid_i & id_ex_mem_read_i & rd_nonzero & rd_match
                   & ~branch_taken_i;

    // Opcode/funct/rd/imm bits are irrelevant to hazard detection.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{if_id_instr_i[ILEN-1:RS2_LSB+REG_W],
                                 if_id_instr_i[RS1_LSB-1:0]};

endmodule : hazard_detect

// File: rtl/if_id_stage.sv
// ----------------------------------------------------------------------------
// if_id_stage
// Fetch front of the five-stage pipeline: program counter, IF/ID register and
// load-use hazard detection. State updates on the falling edge of clk, matching
// the other pipeline registers; reset is asynchronous and active-low.
// Parameters:
//   RESET_PC        - fetch address loaded on reset
// Ports:
//   clk, reset                  - clock (falling-edge active), async reset (low)
//   instr_in                    - instruction memory data for pc_out
//   branch_taken, branch_target - redirect from EX/MEM branch resolution
//   ID_EX_mem_read, ID_EX_rd    - load info currently held in ID/EX
//   pc_out                      - current fetch PC
//   IF_ID_pc_out/instr_out/valid_out - IF/ID register contents
//   stall_out                   - load-use stall, decode zeroes ID/EX controls
//   flush_out                   - equals branch_taken, decode squashes ID/EX
//   stall_count, flush_count    - performance counters
// Optional feature: define IF_ID_PERF_CNT_EN to build saturating stall/flush
// counters; otherwise both counter outputs are tied to zero.
// ----------------------------------------------------------------------------
module if_id_stage
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ILEN-1:0]  instr_in,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             ID_EX_mem_read,
    input  logic [REG_W-1:0] ID_EX_rd,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  IF_ID_pc_out,
    output logic [ILEN-1:0]  IF_ID_instr_out,
    output logic             IF_ID_valid_out,
    output logic             stall_out,
    output logic             flush_out,
    output logic [31:0]      stall_count,
    output logic [31:0]      flush_count
);

    logic [XLEN-1:0] pc_q,          pc_d;
    logic [XLEN-1:0] if_id_pc_q,    if_id_pc_d;
    logic [ILEN-1:0] if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            stall;

    hazard_detect u_hazard_detect (
        .if_id_instr_i    (if_id_instr_q),
        .if_id_valid_i    (if_id_valid_q),
        .id_ex_mem_read_i (ID_EX_mem_read),
        .id_ex_rd_i       (ID_EX_rd),
        .branch_taken_i   (branch_taken),
        .stall_o          (stall)
    );

    // Next-state: redirect beats stall beats sequential fetch.
    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        if (branch_taken) begin
            pc_d          = branch_target;
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d          = pc_q + PC_INC;   // 64-bit wrap is intentional
            if_id_pc_d    = pc_q;
            if_id_instr_d = instr_in;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign pc_out          = pc_q;
    assign IF_ID_pc_out    = if_id_pc_q;
    assign IF_ID_instr_out = if_id_instr_q;
    assign IF_ID_valid_out = if_id_valid_q;
    assign stall_out       = stall;
    assign flush_out       = branch_taken;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: stop at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (branch_taken && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule : if_id_stage

// File: tb/tb_if_id_stage.sv
// ----------------------------------------------------------------------------
// tb_if_id_stage
// Directed bench for if_id_stage with RESET_PC = 64'h100. The DUT acts on the
// falling edge; inputs are changed and outputs sampled just after the rising
// edge, half a period away from the active edge.
// ----------------------------------------------------------------------------
module tb_if_id_stage;
    import pipe_pkg::*;

    localparam logic [63:0] RST_PC = 64'h100;
    localparam logic [31:0] I_ADD  = 32'h0020_82B3;  // add  x5,x1,x2  rs1=1 rs2=2
    localparam logic [31:0] I_ADDI = 32'h0031_0393;  // addi x7,x2,3   rs1=2 rs2 field=3

`ifdef IF_ID_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b1;
    logic        reset;
    logic [31:0] instr_in;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        ID_EX_mem_read;
    logic [4:0]  ID_EX_rd;
    logic [63:0] pc_out;
    logic [63:0] IF_ID_pc_out;
    logic [31:0] IF_ID_instr_out;
    logic        IF_ID_valid_out;
    logic        stall_out;
    logic        flush_out;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_id_stage #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_in        (instr_in),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .ID_EX_mem_read  (ID_EX_mem_read),
        .ID_EX_rd        (ID_EX_rd),
        .pc_out          (pc_out),
        .IF_ID_pc_out    (IF_ID_pc_out),
        .IF_ID_instr_out (IF_ID_instr_out),
        .IF_ID_valid_out (IF_ID_valid_out),
        .stall_out       (stall_out),
        .flush_out       (flush_out),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One falling (active) edge, then return just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if_id(input string tag, input logic [63:0] pc,
                             input logic [63:0] ipc, input logic [31:0] ins,
                             input logic vld);
        chk({tag, ".pc"},    pc_out,          pc);
        chk({tag, ".ifpc"},  IF_ID_pc_out,    ipc);
        chk({tag, ".instr"}, {32'h0, IF_ID_instr_out}, {32'h0, ins});
        chk({tag, ".valid"}, {63'h0, IF_ID_valid_out}, {63'h0, vld});
    endtask

    task automatic chk_reset_state(input string tag);
        chk_if_id(tag, RST_PC, 64'h0, NOP_INSTR, 1'b0);
        chk({tag, ".scnt"}, {32'h0, stall_count}, 64'h0);
        chk({tag, ".fcnt"}, {32'h0, flush_count}, 64'h0);
    endtask

    initial begin
        reset          = 1'b0;
        instr_in       = I_ADD;
        branch_taken   = 1'b0;
        branch_target  = 64'h0;
        ID_EX_mem_read = 1'b0;
        ID_EX_rd       = 5'd0;
        @(posedge clk); #1;

        // Reset state
        chk_reset_state("rst");
        chk("rst.stall", {63'h0, stall_out}, 64'h0);
        chk("rst.flush", {63'h0, flush_out}, 64'h0);
        tick();
        chk_reset_state("rst_hold");

        // Sequential fetch from RESET_PC
        reset = 1'b1; #1;
        tick();
        chk_if_id("seq0", 64'h104, 64'h100, I_ADD, 1'b1);
        $display("seq0: pc=%h ifpc=%h", pc_out, IF_ID_pc_out);
        instr_in = I_ADDI;
        tick();
        chk_if_id("seq1", 64'h108, 64'h104, I_ADDI, 1'b1);
        $display("seq1: pc=%h ifpc=%h", pc_out, IF_ID_pc_out);
        instr_in = I_ADD;
        tick();
        chk_if_id("seq2", 64'h10C, 64'h108, I_ADD, 1'b1);
        $display("seq2: pc=%h ifpc=%h", pc_out, IF_ID_pc_out);

        // Hazard combinations with add x5,x1,x2 in IF/ID
        ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd0; #1;
        chk("hz.rd0", {63'h0, stall_out}, 64'h0);
        ID_EX_mem_read = 1'b0; ID_EX_rd = 5'd1; #1;
        chk("hz.nold", {63'h0, stall_out}, 64'h0);
        ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd5; #1;
        chk("hz.nomatch", {63'h0, stall_out}, 64'h0);
        ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd2; #1;
        chk("hz.rs2", {63'h0, stall_out}, 64'h1);
        ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd1; #1;
        chk("hz.rs1", {63'h0, stall_out}, 64'h1);
        chk("hz.flush", {63'h0, flush_out}, 64'h0);

        // Stall 1: hold for one edge, then advance
        instr_in = I_ADDI;
        tick();
        chk_if_id("stall1", 64'h10C, 64'h108, I_ADD, 1'b1);
        $display("stall1: pc=%h ifpc=%h", pc_out, IF_ID_pc_out);
        ID_EX_mem_read = 1'b0; #1;
        chk("stall1.release", {63'h0, stall_out}, 64'h0);
        tick();
        chk_if_id("adv1", 64'h110, 64'h10C, I_ADDI, 1'b1);

        // Stalls 2 and 3 on addi x7,x2,3 (rs2 field 3, then rs1 2)
        ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd3; #1;
        chk("stall2.req", {63'h0, stall_out}, 64'h1);
        tick();
        ID_EX_rd = 5'd2; #1;
        chk("stall3.req", {63'h0, stall_out}, 64'h1);
        tick();
        chk_if_id("stall3", 64'h110, 64'h10C, I_ADDI, 1'b1);
        ID_EX_mem_read = 1'b0; instr_in = I_ADD;
        tick();
        chk_if_id("adv2", 64'h114, 64'h110, I_ADD, 1'b1);

        // Branch while stall conditions also hold: branch wins
        ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd1;
        branch_taken = 1'b1; branch_target = 64'h200; #1;
        chk("br.stall", {63'h0, stall_out}, 64'h0);
        chk("br.flush", {63'h0, flush_out}, 64'h1);
        tick();
        chk_if_id("br1", 64'h200, 64'h0, NOP_INSTR, 1'b0);
        $display("br1: pc=%h instr=%h", pc_out, IF_ID_instr_out);
        branch_taken = 1'b0; #1;
        chk("br1.nostall", {63'h0, stall_out}, 64'h0);

        // Second branch to the top of the address space, then wrap
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        chk("br2.pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        branch_taken = 1'b0; ID_EX_mem_read = 1'b0; instr_in = I_ADDI;
        tick();
        chk_if_id("wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, I_ADDI, 1'b1);
        $display("wrap: pc=%h ifpc=%h", pc_out, IF_ID_pc_out);

        chk("cnt.stall", {32'h0, stall_count}, PERF ? 64'd3 : 64'd0);
        chk("cnt.flush", {32'h0, flush_count}, PERF ? 64'd2 : 64'd0);

        // Asynchronous reset mid-redirect, between clock edges
        branch_taken = 1'b1; branch_target = 64'h300; #1;
        reset = 1'b0; #1;
        chk_reset_state("arst");
        branch_taken = 1'b0;
        tick();
        reset = 1'b1; instr_in = I_ADD;
        tick();
        chk_if_id("rerun", 64'h104, 64'h100, I_ADD, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_if_id_stage
